dmem_arbiter: RTL

- Shares the single-port MEMSTAGE data memory (1024 x 32, word index = ALU_MEM_Addr[11:2]) between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the loader/DMA engine used for program/data preload and debug readback.
- Arbitration is port-0 priority with a starvation guard and an optional port-1 lock for atomic multi-word transfers.
- Drives MEMSTAGE's Mem_WrEn / ALU_MEM_Addr / MEM_DataIn and returns MEM_DataOut as a registered, 1-cycle-latency read response.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_rsp_reg.sv | 27 ++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, port indices
// and the arbiter state encoding.
package dmem_arbiter_pkg;

   localparam int unsigned DEF_DATA_W       = 32;
   localparam int unsigned DEF_ADDR_W       = 32;
   localparam int unsigned DEF_STARVE_LIMIT = 4;
   localparam int unsigned DEF_LOCK_MAX     = 16;

   localparam int unsigned P0 = 0;
   localparam int unsigned P1 = 1;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_LOCK1 = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-port read response register: captures memory read data at the end of a
// read-grant cycle and raises rvalid for exactly one cycle.
module dmem_rsp_reg #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_grant,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   // rdata holds the last read result until the next read on this port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= rd_grant;
         if (rd_grant) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port-0 priority with a
// starvation guard for port 1 and an optional port-1 burst lock.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int unsigned LOCK_MAX     = DEF_LOCK_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic              p1_lock,
   output logic              p1_ack,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned LC_W = $clog2(LOCK_MAX + 1);

   arb_state_e      state, state_nxt;
   logic [SC_W-1:0] starve_cnt, starve_nxt;
   logic [LC_W-1:0] lock_cnt, lock_nxt;
   logic            grant0, grant1;

   // Grant decision; gated by rst_n so every output is quiet during reset
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      lock_nxt   = lock_cnt;
      grant0     = 1'b0;
      grant1     = 1'b0;
      if (!rst_n) begin
         state_nxt = ST_ARB;
      end else if (state == ST_LOCK1 && p1_req && p1_lock &&
                   lock_cnt < LC_W'(LOCK_MAX)) begin
         grant1   = 1'b1;
         lock_nxt = lock_cnt + LC_W'(1);
      end else begin
         // Leaving LOCK1 falls through here, so the exit cycle follows ARB rules
         state_nxt = ST_ARB;
         if (p0_req && p1_req) begin
            if (starve_cnt == SC_W'(STARVE_LIMIT)) begin
               grant1 = 1'b1;
            end else begin
               grant0 = 1'b1;
            end
         end else if (p0_req) begin
            grant0 = 1'b1;
         end else if (p1_req) begin
            grant1 = 1'b1;
         end
         if (grant1 || !p1_req) begin
            starve_nxt = '0;
         end else begin
            starve_nxt = starve_cnt + SC_W'(1);
         end
         if (grant1 && p1_lock) begin
            state_nxt = ST_LOCK1;
            lock_nxt  = LC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_ARB;
         starve_cnt <= '0;
         lock_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         lock_cnt   <= lock_nxt;
      end
   end

   assign p0_ack    = grant0;
   assign p1_ack    = grant1;
   assign mem_wren  = (grant0 & p0_we) | (grant1 & p1_we);
   assign mem_addr  = grant0 ? p0_addr  : (grant1 ? p1_addr  : '0);
   assign mem_wdata = grant0 ? p0_wdata : (grant1 ? p1_wdata : '0);

   dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_grant  (grant0 & ~p0_we),
      .mem_rdata (mem_rdata),
      .rvalid    (p0_rvalid),
      .rdata     (p0_rdata)
   );

   dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_grant  (grant1 & ~p1_we),
      .mem_rdata (mem_rdata),
      .rvalid    (p1_rvalid),
      .rdata     (p1_rdata)
   );

endmodule
